fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Issues word-aligned reads to instruction memory and presents one
// instruction per cycle to decode. A one-entry skid buffer holds a
// returned word that decode could not accept. A redirect flushes
// everything and restarts fetch at the new target.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one dead cycle after reset or redirect
    S_REQ  = 2'd1,  // request outstanding at fetch_pc
    S_HOLD = 2'd2   // returned word parked in the skid buffer
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_insn_q, skid_insn_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic        valid_q, valid_d;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; redirect wins over every other event.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred
    // on paths that do not assign state_d explicitly.
    state_d = state_q;
    if (redirect_in) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (imem_ack_in && stall_in) state_d = S_HOLD;
        S_HOLD: if (!stall_in) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Memory request outputs, decoded from the current state only.
  always_comb begin
    imem_req_out  = (state_q == S_REQ);
    imem_addr_out = {fetch_pc_q[31:2], 2'b00};
  end

  // Datapath next values: fetch pointer, skid buffer, decode outputs.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    pc_d        = pc_q;
    insn_d      = insn_q;
    valid_d     = valid_q;
    if (redirect_in) begin
      // Any ack arriving now is consumed and its data dropped.
      fetch_pc_d  = {redirect_pc_in[31:2], 2'b00};
      skid_pc_d   = '0;
      skid_insn_d = '0;
      valid_d     = 1'b0;
      insn_d      = NOP_WORD;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_ack_in) begin
            // Address wraps naturally modulo 2^32.
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (stall_in) begin
              skid_pc_d   = fetch_pc_q;
              skid_insn_d = imem_data_in;
            end else begin
              pc_d    = fetch_pc_q;
              insn_d  = imem_data_in;
              valid_d = 1'b1;
            end
          end else if (!stall_in) begin
            // Decode consumed the last instruction and nothing new arrived.
            valid_d = 1'b0;
            insn_d  = NOP_WORD;
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            pc_d    = skid_pc_q;
            insn_d  = skid_insn_q;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      skid_pc_q   <= '0;
      skid_insn_q <= '0;
      pc_q        <= RESET_PC;
      insn_q      <= NOP_WORD;
      valid_q     <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      skid_pc_q   <= skid_pc_d;
      skid_insn_q <= skid_insn_d;
      pc_q        <= pc_d;
      insn_q      <= insn_d;
      valid_q     <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign insn_out  = insn_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8002_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_data_in = '0;
  logic [31:0] pc_out;
  logic [31:0] insn_out;
  logic        valid_out;

  always #5 clk_in = ~clk_in;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .stall_in      (stall_in),
    .redirect_in   (redirect_in),
    .redirect_pc_in(redirect_pc_in),
    .imem_req_out  (imem_req_out),
    .imem_addr_out (imem_addr_out),
    .imem_ack_in   (imem_ack_in),
    .imem_data_in  (imem_data_in),
    .pc_out        (pc_out),
    .insn_out      (insn_out),
    .valid_out     (valid_out)
  );

  // Behavioural model: a fetch pointer, a queue of returned-but-unaccepted
  // words, a "restarting" flag, and the instruction currently shown to decode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  entry_t      parked[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pc;
  logic [31:0] m_insn;
  logic        m_valid;
  bit          m_restart;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit m_req();
    return !m_restart && (parked.size() == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    parked.delete();
    m_fetch_pc = RESET_PC;
    m_pc       = RESET_PC;
    m_insn     = NOP;
    m_valid    = 1'b0;
    m_restart  = 1'b1;
  endtask

  // Advance the model by one clock edge given that cycle's inputs.
  task automatic model_step(input bit stall, input bit redir, input logic [31:0] rpc,
                            input bit ack, input logic [31:0] data);
    entry_t e;
    if (redir) begin
      m_fetch_pc = rpc & 32'hFFFF_FFFC;
      parked.delete();
      m_valid   = 1'b0;
      m_insn    = NOP;
      m_restart = 1'b1;
    end else if (m_restart) begin
      m_restart = 1'b0;
    end else if (parked.size() != 0) begin
      if (!stall) begin
        e       = parked.pop_front();
        m_pc    = e.pc;
        m_insn  = e.insn;
        m_valid = 1'b1;
      end
    end else if (ack) begin
      if (stall) begin
        e.pc   = m_fetch_pc;
        e.insn = data;
        parked.push_back(e);
      end else begin
        m_pc    = m_fetch_pc;
        m_insn  = data;
        m_valid = 1'b1;
      end
      m_fetch_pc = m_fetch_pc + 32'd4;
    end else if (!stall) begin
      m_valid = 1'b0;
      m_insn  = NOP;
    end
  endtask

  // The per-cycle comparison of all DUT outputs against the model.
  task automatic compare_all();
    check("imem_req", imem_req_out, m_req());
    if (m_req()) check("imem_addr", imem_addr_out, m_fetch_pc);
    check("addr_align", imem_addr_out & 32'h3, 32'h0);
    check("pc_out", pc_out, m_pc);
    check("insn_out", insn_out, m_insn);
    check("valid_out", valid_out, m_valid);
  endtask

  // Drive one cycle of inputs at a negedge, clock, update model, compare.
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc,
                      input bit ack, input logic [31:0] data);
    stall_in       = stall;
    redirect_in    = redir;
    redirect_pc_in = rpc;
    imem_ack_in    = ack;
    imem_data_in   = data;
    @(posedge clk_in);
    model_step(stall, redir, rpc, ack, data);
    @(negedge clk_in);
    compare_all();
  endtask

  // Memory that acks immediately with data equal to the address.
  task automatic fetch(input bit stall);
    step(stall, 1'b0, 32'h0, m_req(), m_fetch_pc);
  endtask

  // Asynchronous reset pulse between clock edges, released on a negedge.
  task automatic pulse_reset();
    stall_in    = 1'b0;
    redirect_in = 1'b0;
    imem_ack_in = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", valid_out, 1'b0);
    check("rst_pc", pc_out, RESET_PC);
    check("rst_insn", insn_out, NOP);
    check("rst_req", imem_req_out, 1'b0);
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    logic        r_stall, r_redir, r_ack;
    logic [31:0] r_rpc;

    model_reset();
    repeat (2) @(negedge clk_in);
    check("init_pc", pc_out, 32'h8002_0000);
    check("init_valid", valid_out, 1'b0);
    check("init_insn", insn_out, 32'h0);
    check("init_req", imem_req_out, 1'b0);
    rst_n = 1'b1;
    compare_all();

    // Streaming with an always-ack memory.
    fetch(1'b0);
    check("first_req", imem_req_out, 1'b1);
    check("first_addr", imem_addr_out, 32'h8002_0000);
    fetch(1'b0);
    check("stream_addr1", imem_addr_out, 32'h8002_0004);
    check("stream_valid1", valid_out, 1'b1);
    check("stream_pc1", pc_out, 32'h8002_0000);
    check("stream_insn1", insn_out, 32'h8002_0000);
    fetch(1'b0);
    check("stream_pc2", pc_out, 32'h8002_0004);
    check("stream_addr2", imem_addr_out, 32'h8002_0008);

    // Ack at 8002_0008 while decode stalls for two cycles.
    fetch(1'b1);
    check("skid_hold_pc", pc_out, 32'h8002_0004);
    check("skid_hold_req", imem_req_out, 1'b0);
    fetch(1'b1);
    check("skid_hold_pc2", pc_out, 32'h8002_0004);
    check("skid_hold_valid", valid_out, 1'b1);
    fetch(1'b0);
    check("skid_release_pc", pc_out, 32'h8002_0008);
    check("skid_release_valid", valid_out, 1'b1);
    check("skid_next_addr", imem_addr_out, 32'h8002_000C);

    // Ack withheld for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("gap_addr", imem_addr_out, 32'h8002_000C);
      check("gap_valid", valid_out, 1'b0);
      check("gap_insn", insn_out, 32'h0);
    end
    fetch(1'b0);
    check("gap_end_pc", pc_out, 32'h8002_000C);

    // Redirect coinciding with an ack.
    step(1'b0, 1'b1, 32'h8002_0103, 1'b1, 32'hDEAD_BEEF);
    check("redir_valid", valid_out, 1'b0);
    check("redir_insn", insn_out, 32'h0);
    check("redir_idle", imem_req_out, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("redir_addr", imem_addr_out, 32'h8002_0100);

    // Redirect under stall still flushes; then address wrap.
    fetch(1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("redir_stall_valid", valid_out, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch(1'b0);
    check("wrap_addr", imem_addr_out, 32'h0000_0000);
    check("wrap_pc", pc_out, 32'hFFFF_FFFC);

    // Reset in the middle of HOLD.
    fetch(1'b0);
    fetch(1'b1);
    pulse_reset();
    fetch(1'b0);
    check("rst_hold_addr", imem_addr_out, 32'h8002_0000);

    // Reset in the middle of a request.
    pulse_reset();
    fetch(1'b0);
    fetch(1'b0);
    check("rst_req_pc", pc_out, 32'h8002_0000);
    check("rst_req_valid", valid_out, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) pulse_reset();
      r_stall = ($urandom_range(0, 9) < 3);
      r_redir = ($urandom_range(0, 99) < 4);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      r_ack   = m_req() && ($urandom_range(0, 9) < 6);
      step(r_stall, r_redir, r_rpc, r_ack, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
